// File: rtl/div_clk_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Optional build macro used by this slice: MON_SYNC_EN (adds an input synchronizer).
package div_clk_monitor_pkg;

    // Monitor FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } mon_state_e;

    // Defaults matching the divide-by-2 stage
    localparam int EXP_PERIOD_DIV2 = 2;
    localparam int LOCK_CNT_DEF    = 4;
    localparam int TIMEOUT_DEF     = 16;

    // Match counter width; LOCK_CNT is limited to 1..15
    localparam int MATCH_W = 4;

    // Saturating increment of the match counter
    function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] v,
                                                     input logic [MATCH_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// Signal bundle between the divider/system side and the divided-clock monitor.
// The master modport is the monitor itself; slave is the system side using its results.
interface div_clk_monitor_if #(
    parameter int CW = 8
) ();
    logic          en;
    logic          div_clk_i;
    logic [CW-1:0] period_o;
    logic          period_vld_o;
    logic          lock_o;
    logic          err_o;
    logic          timeout_o;

    modport master (
        input  en,
        input  div_clk_i,
        output period_o,
        output period_vld_o,
        output lock_o,
        output err_o,
        output timeout_o
    );

    modport slave (
        output en,
        output div_clk_i,
        input  period_o,
        input  period_vld_o,
        input  lock_o,
        input  err_o,
        input  timeout_o
    );
endinterface

// File: rtl/div_clk_monitor_edge_det.sv
// Rising-edge detector for a clock-like signal sampled as data.
// With MON_SYNC_EN defined a 2-FF synchronizer precedes the sample register
// (rise latency 3 cycles); otherwise the input must already be in the clk domain
// (rise latency 1 cycle).
module div_clk_monitor_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_in;

`ifdef MON_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-stage synchronizer for a source in a foreign clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign d_in = sync2_q;
`else
    assign d_in = d_i;
`endif

    logic s_q;
    logic p_q;

    // Sample register and its one-cycle delayed copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            s_q <= d_in;
            p_q <= s_q;
        end
    end

    assign rise_o = s_q & ~p_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures the period of div_clk_i in clk cycles,
// reports lock after LOCK_CNT consecutive matching periods, flags mismatches
// and missing edges. Build macro MON_SYNC_EN inserts an input synchronizer.
module div_clk_monitor
    import div_clk_monitor_pkg::*;
#(
    parameter int CW         = 8,
    parameter int EXP_PERIOD = EXP_PERIOD_DIV2,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               rst_n,
    div_clk_monitor_if.master mon_if
);

    localparam logic [CW-1:0]      CNT_MAX  = '1;
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      EXP_C    = CW'(EXP_PERIOD);
    localparam logic [CW-1:0]      TO_C     = CW'(TIMEOUT);
    // ARM counts from 0, so TIMEOUT idle cycles end when the count shows TIMEOUT-1
    localparam logic [CW-1:0]      TO_ARM_C = CW'(TIMEOUT - 1);
    localparam logic [MATCH_W-1:0] LOCK_C   = MATCH_W'(LOCK_CNT);

    logic rise;

    div_clk_monitor_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (mon_if.div_clk_i),
        .rise_o (rise)
    );

    mon_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_d;
    logic [CW-1:0]      period_q;
    logic               period_vld_q;
    logic               lock_q;
    logic               err_q;
    logic               timeout_q;

    // Saturating cycle counter and match counter increments
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign match_d = match_inc(match_q, LOCK_C);

    // Monitor FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            match_q      <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            period_vld_q <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            if (!mon_if.en) begin
                // Disable wins over everything; the last period is kept
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                match_q <= '0;
                lock_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                        cnt_q   <= '0;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            // First edge only starts the measurement
                            cnt_q   <= CNT_ONE;
                            state_q <= ST_MEAS;
                        end else if (cnt_q >= TO_ARM_C) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            // A rise beats a simultaneous timeout and is judged as a period
                            period_q     <= cnt_q;
                            period_vld_q <= 1'b1;
                            cnt_q        <= CNT_ONE;
                            if (cnt_q == EXP_C) begin
                                match_q <= match_d;
                                if (match_d == LOCK_C) begin
                                    lock_q <= 1'b1;
                                end
                            end else begin
                                err_q   <= 1'b1;
                                match_q <= '0;
                                lock_q  <= 1'b0;
                            end
                        end else if (cnt_q >= TO_C) begin
                            timeout_q <= 1'b1;
                            lock_q    <= 1'b0;
                            match_q   <= '0;
                            cnt_q     <= '0;
                            state_q   <= ST_ARM;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign mon_if.period_o     = period_q;
    assign mon_if.period_vld_o = period_vld_q;
    assign mon_if.lock_o       = lock_q;
    assign mon_if.err_o        = err_q;
    assign mon_if.timeout_o    = timeout_q;

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Downstream consumer of the divided clock produced by the divider stage.
- Samples the divided clock as a data signal in the `clk` domain and detects its rising edges.
- Measures the period in `clk` cycles and checks it against an expected value.
- Reports lock, error and timeout so system logic can qualify the divider before using its output.

Parameters:
- CW, 8, width of the period counter and the period output.
- EXP_PERIOD, 2, expected period in `clk` cycles. The default matches the divide-by-2 stage.
- LOCK_CNT, 4, number of consecutive matching periods required to assert lock. Legal range 1..15.
- TIMEOUT, 16, number of `clk` cycles without a rising edge before a timeout is flagged. Must satisfy EXP_PERIOD < TIMEOUT < 2^CW.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable; 0 forces IDLE.
- div_clk_i  in  1  divided clock from the divider stage, sampled as data.
- period_o  out  CW  last measured period; holds its value between updates.
- period_vld_o  out  1  1-cycle pulse when period_o updates.
- lock_o  out  1  level; asserted after LOCK_CNT consecutive matching periods.
- err_o  out  1  1-cycle pulse on a period mismatch.
- timeout_o  out  1  1-cycle pulse when no edge arrives within TIMEOUT cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, state IDLE, counters 0, sample registers 0.
- Edge detect:
  - s is div_clk_i registered; p is s delayed by one cycle; rise = s & ~p.
  - rise is valid 1 cycle after div_clk_i rises (latency 1).
- FSM states: IDLE, ARM, MEAS.
  - IDLE: en=1 → ARM.
  - ARM: waiting for the first rise. On rise: cnt←1, go to MEAS, no period output. If TIMEOUT cycles pass with no rise: timeout_o pulse, cnt←0, stay in ARM.
  - MEAS, cnt increments each cycle, saturating at 2^CW−1.
  - MEAS, on rise:
    - period_o←cnt, period_vld_o pulse, cnt←1.
    - If cnt==EXP_PERIOD: match_cnt increments, saturating at LOCK_CNT; lock_o←1 when match_cnt reaches LOCK_CNT.
    - Else: err_o pulse, match_cnt←0, lock_o←0.
  - MEAS, if cnt reaches TIMEOUT without a rise: timeout_o pulse, lock_o←0, match_cnt←0, go to ARM.
  - Any state, en=0: go to IDLE next cycle; lock_o←0; match_cnt and cnt cleared; period_o holds. Pulses are suppressed in the same cycle en drops.
- Simultaneous events:
  - Rise in the same cycle cnt hits TIMEOUT: the rise wins and is treated as a normal mismatch (cnt ≠ EXP_PERIOD) → err_o, not timeout_o.
- Pulse exclusivity: err_o and timeout_o are never high together. period_vld_o may coincide with err_o.
- Reset asserted mid-measurement: immediate return to reset values. The first rise after release only arms the monitor.

Optional Feature:
- Macro MON_SYNC_EN.
- Defined: div_clk_i passes through a 2-FF synchronizer before s, for use when the divider sits in another domain. Edge latency becomes 3 cycles; measured periods are unchanged.
- Undefined: no synchronizer; latency 1. This is only valid when div_clk_i is registered in the `clk` domain.

Decomposition:
- Shared package:
  - State typedef (IDLE/ARM/MEAS), 2-bit encoding.
  - Default constants EXP_PERIOD_DIV2=2, LOCK_CNT_DEF=4, TIMEOUT_DEF=16.
- Sub-module edge_det: optional synchronizer plus rise detection, output rise. Reusable by other monitors.

Test Plan:
- Divide-by-2 stage feeding div_clk_i (toggles every clk), en=1 → first rise arms only; period_vld_o every 2 cycles with period_o=2; lock_o rises on the 4th matching period; no err_o.
- Drive a period of 3 for one cycle inside a period-2 stream after lock → period_o=3, err_o pulse, lock_o=0; lock_o returns after 4 further period-2 edges.
- Hold div_clk_i=0 after lock → timeout_o pulse exactly 16 cycles after the last rise; lock_o=0; state ARM; the next rise produces no period_vld_o.
- Rise arriving exactly when cnt=TIMEOUT=16 → err_o pulse, period_o=16, timeout_o stays 0.
- Drop en mid-stream, reassert after 5 cycles → lock_o=0 immediately; period_o keeps its last value; the first rise after re-enable only arms.
- Assert rst_n=0 asynchronously between clk edges during MEAS → all outputs 0 without waiting for a clk edge. After release, a period-2 stream locks after 1 arming rise plus 4 matching periods.
- MON_SYNC_EN defined → period values identical to the first scenario; first period_vld_o delayed by 2 extra cycles.
